// File: rtl/product_accumulator_pkg.sv
// product_accumulator_pkg: shared constants and FSM state type for the product accumulator
package product_accumulator_pkg;
  localparam int PROD_W = 16;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;
endpackage

// File: rtl/pacc_sat_add.sv
// pacc_sat_add: W-bit unsigned add with carry out, clamping to all-ones when PRODUCT_ACCUMULATOR_SAT_EN is defined
// Ports: a, b (addends), sum (wrapped or clamped result), carry (carry out of bit W-1).
module pacc_sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);
  logic [W:0] raw;
  always_comb begin
    raw   = {1'b0, a} + {1'b0, b};
    carry = raw[W];
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    sum   = carry ? '1 : raw[W-1:0];
`else
    sum   = raw[W-1:0];
`endif
  end
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums LEN unsigned 16-bit products and presents the result with a valid/ready handshake
// Ports: clk, rst (sync active-high); in_valid/in_ready/in_prod upstream beat; in_clear aborts the partial sum;
// out_valid/out_ready/out_sum/out_ovf downstream result. Define PRODUCT_ACCUMULATOR_SAT_EN for saturating sums.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int ACC_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);
  localparam int CNT_W = 8;
  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, prod_ext, add_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d, in_ready_q, in_ready_d;
  logic             fire, carry;
  assign prod_ext = ACC_W'(in_prod);
  assign fire     = in_valid && in_ready_q;
  pacc_sat_add #(.W(ACC_W)) u_add (
    .a     (acc_q),
    .b     (prod_ext),
    .sum   (add_sum),
    .carry (carry)
  );
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (in_clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (fire) begin
          acc_d   = prod_ext;
          cnt_d   = CNT_W'(1);
          state_d = (LEN == 1) ? HOLD : ACCUM;
        end
        ACCUM: if (fire) begin
          acc_d   = add_sum;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_d == CNT_W'(LEN)) ? HOLD : ACCUM;
        end
        HOLD: state_d = out_ready ? IDLE : HOLD;
        default: state_d = IDLE;
      endcase
    end
    out_valid_d = (state_d == HOLD);
    in_ready_d  = (state_d != HOLD);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  logic ovf_q, ovf_d;
  // sticky per result: restarts with the first beat of a new result
  always_comb
    ovf_d = (in_clear || (fire && state_q == IDLE)) ? 1'b0 : (ovf_q || (fire && state_q == ACCUM && carry));
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign out_ovf = ovf_q && out_valid_q;
`else
  logic unused_carry;
  assign unused_carry = carry;
  assign out_ovf      = 1'b0;
`endif
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_sum   = acc_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed self-checking bench for product_accumulator in three configurations
module tb_product_accumulator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv[3], ic[3], ordy[3];
  logic [15:0] ip[3];
  logic        ir[3], ov[3], oo[3];
  logic [23:0] sa;
  logic [16:0] sb;
  logic [15:0] sc;
  int n_cmp = 0;
  int n_bad = 0;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  localparam logic [16:0] EXP_B_SUM = 17'd131071;
  localparam logic        EXP_B_OVF = 1'b1;
`else
  localparam logic [16:0] EXP_B_SUM = 17'd129028;
  localparam logic        EXP_B_OVF = 1'b0;
`endif
  always #5 clk = ~clk;
  product_accumulator #(.LEN(4), .ACC_W(24)) u_a (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_prod(ip[0]), .in_clear(ic[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(sa), .out_ovf(oo[0]));
  product_accumulator #(.LEN(4), .ACC_W(17)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_prod(ip[1]), .in_clear(ic[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(sb), .out_ovf(oo[1]));
  product_accumulator #(.LEN(1), .ACC_W(16)) u_c (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_prod(ip[2]), .in_clear(ic[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(sc), .out_ovf(oo[2]));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int d, input logic v, input logic [15:0] p, input logic c, input logic r);
    iv[d] = v; ip[d] = p; ic[d] = c; ordy[d] = r;
  endtask
  task automatic test_reset;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 16'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n_cmp++; if (ov[d] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", d, ov[d]); end
      n_cmp++; if (oo[d] !== 1'b0) begin n_bad++; $display("FAIL reset_out_ovf[%0d]: got %b expected 0", d, oo[d]); end
      n_cmp++; if (ir[d] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", d, ir[d]); end
    end
    n_cmp++; if (sa !== 24'd0) begin n_bad++; $display("FAIL reset_sum_a: got %0d expected 0", sa); end
    n_cmp++; if (sb !== 17'd0) begin n_bad++; $display("FAIL reset_sum_b: got %0d expected 0", sb); end
    n_cmp++; if (sc !== 16'd0) begin n_bad++; $display("FAIL reset_sum_c: got %0d expected 0", sc); end
  endtask
  task automatic test_basic;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 16'd65025, 1'b0, 1'b0);
      tick;
      n_cmp++; if (ov[0] !== (i == 3)) begin n_bad++; $display("FAIL basic_valid_beat%0d: got %b expected %b", i, ov[0], i == 3); end
    end
    drive(0, 1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (sa !== 24'd260100) begin n_bad++; $display("FAIL basic_sum: got %0d expected 260100", sa); end
    n_cmp++; if (oo[0] !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b expected 0", oo[0]); end
    n_cmp++; if (ir[0] !== 1'b0) begin n_bad++; $display("FAIL basic_ready_hold: got %b expected 0", ir[0]); end
    drive(0, 1'b0, 16'd0, 1'b0, 1'b1);
    tick;
    drive(0, 1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL basic_release_valid: got %b expected 0", ov[0]); end
    n_cmp++; if (ir[0] !== 1'b1) begin n_bad++; $display("FAIL basic_release_ready: got %b expected 1", ir[0]); end
  endtask
  task automatic test_overflow;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, 16'd65025, 1'b0, 1'b0);
      tick;
    end
    drive(1, 1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (ov[1] !== 1'b1) begin n_bad++; $display("FAIL ovf_valid: got %b expected 1", ov[1]); end
    n_cmp++; if (sb !== EXP_B_SUM) begin n_bad++; $display("FAIL ovf_sum: got %0d expected %0d", sb, EXP_B_SUM); end
    n_cmp++; if (oo[1] !== EXP_B_OVF) begin n_bad++; $display("FAIL ovf_flag: got %b expected %b", oo[1], EXP_B_OVF); end
    drive(1, 1'b0, 16'd0, 1'b0, 1'b1);
    tick;
    drive(1, 1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (oo[1] !== 1'b0) begin n_bad++; $display("FAIL ovf_flag_idle: got %b expected 0", oo[1]); end
  endtask
  task automatic test_backpressure;
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1'b1, 16'(i), 1'b0, 1'b0);
      tick;
      drive(0, 1'b0, 16'd0, 1'b0, 1'b0);
      if (i < 4) begin
        n_cmp++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin n_bad++; $display("FAIL bp_gap%0d: got valid=%b ready=%b expected valid=0 ready=1", i, ov[0], ir[0]); end
        tick;
        tick;
      end
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid%0d: got %b expected 1", k, ov[0]); end
      n_cmp++; if (sa !== 24'd10) begin n_bad++; $display("FAIL bp_hold_sum%0d: got %0d expected 10", k, sa); end
      n_cmp++; if (ir[0] !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ready%0d: got %b expected 0", k, ir[0]); end
      drive(0, 1'b1, 16'd99, 1'b0, 1'b0);
      tick;
    end
    n_cmp++; if (sa !== 24'd10) begin n_bad++; $display("FAIL bp_ignored_beat: got %0d expected 10", sa); end
    drive(0, 1'b0, 16'd0, 1'b0, 1'b1);
    tick;
    drive(0, 1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin n_bad++; $display("FAIL bp_idle: got valid=%b ready=%b expected valid=0 ready=1", ov[0], ir[0]); end
  endtask
  task automatic test_clear;
    for (int i = 0; i < 2; i++) begin
      drive(0, 1'b1, 16'd100, 1'b0, 1'b0);
      tick;
    end
    drive(0, 1'b1, 16'd100, 1'b1, 1'b0);
    tick;
    n_cmp++; if (sa !== 24'd0) begin n_bad++; $display("FAIL clear_acc: got %0d expected 0", sa); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 16'd7, 1'b0, 1'b0);
      tick;
      n_cmp++; if (ov[0] !== (i == 3)) begin n_bad++; $display("FAIL clear_valid_beat%0d: got %b expected %b", i, ov[0], i == 3); end
    end
    drive(0, 1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (sa !== 24'd28) begin n_bad++; $display("FAIL clear_sum: got %0d expected 28", sa); end
    drive(0, 1'b0, 16'd0, 1'b1, 1'b0);
    tick;
    drive(0, 1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin n_bad++; $display("FAIL clear_hold_drop: got valid=%b ready=%b expected valid=0 ready=1", ov[0], ir[0]); end
    n_cmp++; if (sa !== 24'd0) begin n_bad++; $display("FAIL clear_hold_acc: got %0d expected 0", sa); end
  endtask
  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 16'd50, 1'b0, 1'b0);
      tick;
    end
    drive(0, 1'b0, 16'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++; if (ov[0] !== 1'b0 || oo[0] !== 1'b0 || ir[0] !== 1'b1) begin n_bad++; $display("FAIL rstmid_flags: got valid=%b ovf=%b ready=%b expected 0 0 1", ov[0], oo[0], ir[0]); end
    n_cmp++; if (sa !== 24'd0) begin n_bad++; $display("FAIL rstmid_sum: got %0d expected 0", sa); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 16'd1, 1'b0, 1'b0);
      tick;
    end
    drive(0, 1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (ov[0] !== 1'b1 || sa !== 24'd4) begin n_bad++; $display("FAIL rstmid_result: got valid=%b sum=%0d expected valid=1 sum=4", ov[0], sa); end
    drive(0, 1'b0, 16'd0, 1'b0, 1'b1);
    tick;
    drive(0, 1'b0, 16'd0, 1'b0, 1'b0);
  endtask
  task automatic test_len1;
    drive(2, 1'b1, 16'd65025, 1'b0, 1'b0);
    tick;
    n_cmp++; if (ov[2] !== 1'b1 || sc !== 16'd65025) begin n_bad++; $display("FAIL len1_result: got valid=%b sum=%0d expected valid=1 sum=65025", ov[2], sc); end
    n_cmp++; if (ir[2] !== 1'b0) begin n_bad++; $display("FAIL len1_ready_hold: got %b expected 0", ir[2]); end
    drive(2, 1'b1, 16'd5, 1'b0, 1'b1);
    tick;
    n_cmp++; if (ov[2] !== 1'b0 || ir[2] !== 1'b1) begin n_bad++; $display("FAIL len1_release: got valid=%b ready=%b expected valid=0 ready=1", ov[2], ir[2]); end
    drive(2, 1'b1, 16'd5, 1'b0, 1'b0);
    tick;
    drive(2, 1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (ov[2] !== 1'b1 || sc !== 16'd5) begin n_bad++; $display("FAIL len1_second: got valid=%b sum=%0d expected valid=1 sum=5", ov[2], sc); end
    drive(2, 1'b0, 16'd0, 1'b0, 1'b1);
    tick;
    drive(2, 1'b0, 16'd0, 1'b0, 1'b0);
  endtask
  task automatic test_back_to_back;
    drive(0, 1'b1, 16'd3, 1'b0, 1'b1);
    for (int n = 1; n <= 10; n++) begin
      tick;
      n_cmp++; if (ov[0] !== (n % 5 == 4)) begin n_bad++; $display("FAIL b2b_valid_cycle%0d: got %b expected %b", n, ov[0], n % 5 == 4); end
      if (n % 5 == 4) begin
        n_cmp++; if (sa !== 24'd12) begin n_bad++; $display("FAIL b2b_sum_cycle%0d: got %0d expected 12", n, sa); end
      end
    end
    drive(0, 1'b0, 16'd0, 1'b0, 1'b0);
  endtask
  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_backpressure;
    test_clear;
    test_reset_mid;
    test_len1;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter LEN, default 8: number of products summed per result; legal range 1..255.
REQ-002 Parameter ACC_W, default 24: accumulator and result width; legal range 16..32.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream product valid.
REQ-006 in_ready  output  1  block can accept a product this cycle.
REQ-007 in_prod  input  16  unsigned 8x8 product from the multiplier stage.
REQ-008 in_clear  input  1  synchronous abort: discard the partial sum.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_sum  output  ACC_W  accumulated sum of LEN products.
REQ-012 out_ovf  output  1  overflow occurred during this result; see REQ-027.

Function
REQ-013 A beat is accepted only in a cycle where in_valid=1 and in_ready=1; in_prod is zero-extended to ACC_W.
REQ-014 The FSM has three states: IDLE, ACCUM, HOLD.
REQ-015 In IDLE and ACCUM, in_ready=1; in HOLD, in_ready=0.
REQ-016 IDLE: an accepted beat loads acc=in_prod and cnt=1, then moves to ACCUM, or to HOLD if LEN==1.
REQ-017 ACCUM: an accepted beat does acc=acc+in_prod and cnt=cnt+1; when cnt reaches LEN the next state is HOLD. With no accepted beat, state and acc hold.
REQ-018 HOLD: out_valid=1; out_sum and out_ovf are stable until out_ready=1, which returns the FSM to IDLE in the next cycle.
REQ-019 Latency: out_valid rises in the cycle after the LEN-th beat is accepted.
REQ-020 Throughput: one result per LEN+1 cycles minimum, because of the single HOLD cycle.
REQ-021 out_valid=0 outside HOLD; out_sum is undefined outside HOLD but is driven from the acc register (no X).
REQ-022 in_clear=1 in any state forces IDLE, acc=0, cnt=0 and ovf=0 on the next edge.
REQ-023 in_clear discards any beat accepted in the same cycle and drops a pending HOLD result without handshake.
REQ-024 Priority order: rst > in_clear > handshake.
REQ-025 Arithmetic: unsigned; ACC_W-bit sum, with behaviour at overflow set by the configuration (REQ-027/028).

Reset
REQ-026 rst=1 at any clock edge sets state=IDLE, acc=0, cnt=0, out_valid=0, out_ovf=0, out_sum=0; in_ready=1 from the first cycle after rst deasserts; a reset mid-operation discards the partial sum.

Configuration
REQ-027 With PRODUCT_ACCUMULATOR_SAT_EN defined:
  - A carry out of ACC_W clamps acc to 2^ACC_W-1.
  - It sets a sticky ovf flag for the current result.
  - Subsequent beats keep the sum clamped.
  - out_ovf reflects the flag in HOLD.
REQ-028 Without PRODUCT_ACCUMULATOR_SAT_EN:
  - The sum wraps modulo 2^ACC_W.
  - out_ovf is tied to 0.
  - No saturation logic is instantiated.

Structure
REQ-029 Shared package product_accumulator_pkg holds the constant PROD_W=16 and the FSM state enum (IDLE, ACCUM, HOLD).
REQ-030 One sub-module, pacc_sat_add (ACC_W-bit add with carry out and optional clamp), is instantiated once; all other logic is in the top module.

Verification
REQ-031 LEN=4, ACC_W=24; four beats of 65025 (255x255) back-to-back -> out_valid on cycle 5; out_sum=260100; out_ovf=0.
REQ-032 LEN=4, ACC_W=17; four beats of 65025:
  - With SAT_EN -> out_sum=131071, out_ovf=1.
  - Without SAT_EN -> out_sum=129028, out_ovf=0.
REQ-033 LEN=4; beats 1,2,3,4 with in_valid gaps of 2 cycles, and out_ready=0 for 5 cycles in HOLD:
  - out_sum=10 stays stable and in_ready=0 throughout HOLD.
  - After out_ready=1, the block is in IDLE next cycle.
REQ-034 LEN=4; two beats of 100, then in_clear=1 together with a valid beat; then four beats of 7 -> out_sum=28; the cleared beat is not counted.
REQ-035 LEN=4; rst pulsed for 1 cycle after 3 beats -> all outputs 0; the next four beats of 1 -> out_sum=4.
REQ-036 LEN=1, ACC_W=16; beat 65025 -> out_valid next cycle; out_sum=65025.
